s2_conv_engine: RTL and testbench

S2_CONV_ENGINE -- requirements
Module: s2_conv_engine

---
 rtl/s2_conv_engine.sv | 167 ++++++++++++++++
 tb/tb_s2_conv_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/s2_conv_engine.sv
// rtl/s2_conv_engine.sv - valid-only 2D multi-channel convolution engine with bias and ReLU
// Accumulates one channel slice (K*K products) per cycle, then presents one result per output position.
module s2_conv_engine #(
    parameter int IN_DIM = 8,
    parameter int CH     = 3,
    parameter int K      = 3,
    parameter int NF     = 4,
    parameter int DW     = 17,
    localparam int OD    = IN_DIM - K + 1,
    localparam int AW    = 2 * DW + $clog2(K * K * CH) + 1,
    localparam int NOUT  = NF * OD * OD,
    localparam int IW    = $clog2(NOUT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [IN_DIM*IN_DIM*CH*DW-1:0]  tensor_in,
    input  logic [NF*K*K*CH*DW-1:0]         filt_in,
    input  logic [NF*AW-1:0]                bias_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [AW-1:0]                   out_data,
    output logic [IW-1:0]                   out_idx,
    output logic                            busy,
    output logic                            done
);

    localparam int FW  = (NF > 1) ? $clog2(NF) : 1;
    localparam int RW  = (OD > 1) ? $clog2(OD) : 1;
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int TIW = $clog2(IN_DIM * IN_DIM * CH * DW);
    localparam int FIW = $clog2(NF * K * K * CH * DW);
    localparam int BIW = $clog2(NF * AW);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT, S_FIN} state_t;

    state_t                r_state;
    logic signed [AW-1:0]  r_acc;
    logic [FW-1:0]         r_f;
    logic [RW-1:0]         r_r;
    logic [RW-1:0]         r_c;
    logic [CW-1:0]         r_ch;
    logic [IW-1:0]         r_idx;
    logic                  r_out_valid;
    logic [AW-1:0]         r_out_data;
    logic [IW-1:0]         r_out_idx;
    logic                  r_busy;
    logic                  r_done;

    logic signed [AW-1:0]  w_sum;
    logic signed [AW-1:0]  w_total;
    logic [AW-1:0]         w_relu;
    logic [TIW-1:0]        w_ti;
    logic [FIW-1:0]        w_fi;
    logic [BIW-1:0]        w_bi;

    function automatic logic signed [AW-1:0] mul_ext(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = a * b;
        return {{(AW - 2 * DW){p[2*DW-1]}}, p};
    endfunction

    // One channel slice of the K*K window for the current (f, r, c, ch).
    always_comb begin
        w_sum = '0;
        w_ti  = '0;
        w_fi  = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w_ti  = TIW'((((int'(r_r) + i) * IN_DIM + int'(r_c) + j) * CH + int'(r_ch)) * DW);
                w_fi  = FIW'((((int'(r_f) * K + i) * K + j) * CH + int'(r_ch)) * DW);
                w_sum = w_sum + mul_ext(tensor_in[w_ti +: DW], filt_in[w_fi +: DW]);
            end
        end
    end

    // The last channel's slice folds straight into the result, skipping the accumulator.
    always_comb begin
        w_bi    = BIW'(int'(r_f) * AW);
        w_total = r_acc + w_sum + $signed(bias_in[w_bi +: AW]);
        w_relu  = w_total[AW-1] ? '0 : w_total;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_f         <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_ch        <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACC;
                        r_acc   <= '0;
                        r_f     <= '0;
                        r_r     <= '0;
                        r_c     <= '0;
                        r_ch    <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (r_ch == CW'(CH - 1)) begin
                        r_ch        <= '0;
                        r_out_data  <= w_relu;
                        r_out_idx   <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_acc <= r_acc + w_sum;
                        r_ch  <= r_ch + CW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        if (r_idx == IW'(NOUT - 1)) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ACC;
                            r_idx   <= r_idx + IW'(1);
                            if (r_c == RW'(OD - 1)) begin
                                r_c <= '0;
                                if (r_r == RW'(OD - 1)) begin
                                    r_r <= '0;
                                    r_f <= r_f + FW'(1);
                                end else begin
                                    r_r <= r_r + RW'(1);
                                end
                            end else begin
                                r_c <= r_c + RW'(1);
                            end
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_s2_conv_engine.sv
// tb/tb_s2_conv_engine.sv - self-checking bench for s2_conv_engine
// Expected results come from a direct arithmetic convolution over bench-held arrays.
module tb_s2_conv_engine;

    localparam int IN_DIM = 8;
    localparam int CH     = 3;
    localparam int K      = 3;
    localparam int NF     = 4;
    localparam int DW     = 17;
    localparam int OD     = IN_DIM - K + 1;
    localparam int AW     = 2 * DW + $clog2(K * K * CH) + 1;
    localparam int NOUT   = NF * OD * OD;
    localparam int IW     = $clog2(NOUT);

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic                           start = 1'b0;
    logic                           out_ready = 1'b0;
    logic [IN_DIM*IN_DIM*CH*DW-1:0] tensor_in = '0;
    logic [NF*K*K*CH*DW-1:0]        filt_in = '0;
    logic [NF*AW-1:0]               bias_in = '0;
    logic                           out_valid;
    logic [AW-1:0]                  out_data;
    logic [IW-1:0]                  out_idx;
    logic                           busy;
    logic                           done;

    s2_conv_engine #(.IN_DIM(IN_DIM), .CH(CH), .K(K), .NF(NF), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tensor_in(tensor_in), .filt_in(filt_in), .bias_in(bias_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int     tens [IN_DIM][IN_DIM][CH];
    int     filt [NF][K][K][CH];
    longint bias [NF];
    longint exp_q [NOUT];
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic load_and_model();
        longint s;
        for (int r = 0; r < IN_DIM; r++)
            for (int c = 0; c < IN_DIM; c++)
                for (int ch = 0; ch < CH; ch++)
                    tensor_in[((r * IN_DIM + c) * CH + ch) * DW +: DW] = DW'(tens[r][c][ch]);
        for (int f = 0; f < NF; f++) begin
            bias_in[f * AW +: AW] = AW'(bias[f]);
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    for (int ch = 0; ch < CH; ch++)
                        filt_in[(((f * K + i) * K + j) * CH + ch) * DW +: DW] = DW'(filt[f][i][j][ch]);
        end
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < OD; r++)
                for (int c = 0; c < OD; c++) begin
                    s = bias[f];
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            for (int ch = 0; ch < CH; ch++)
                                s += longint'(filt[f][i][j][ch]) * longint'(tens[r + i][c + j][ch]);
                    exp_q[f * OD * OD + r * OD + c] = (s < 0) ? 64'sd0 : s;
                end
    endtask

    task automatic fill_const(input int v, input longint b);
        foreach (tens[r, c, ch]) tens[r][c][ch] = v;
        foreach (filt[f, i, j, ch]) filt[f][i][j][ch] = v;
        foreach (bias[f]) bias[f] = b;
        load_and_model();
    endtask

    task automatic fill_random();
        logic [DW-1:0] v;
        foreach (tens[r, c, ch]) begin
            v = DW'($urandom);
            tens[r][c][ch] = int'($signed(v));
        end
        foreach (filt[f, i, j, ch]) begin
            v = DW'($urandom);
            filt[f][i][j][ch] = int'($signed(v));
        end
        foreach (bias[f]) bias[f] = longint'(int'($urandom));
        load_and_model();
    endtask

    task automatic run_pass(input int stall_at, input int start_at, input bit start_fin,
                            input int reset_at, input bit rand_ready);
        int            t;
        int            base;
        int            got;
        int            presented;
        int            stall_rem;
        bit            finished;
        logic [AW-1:0] held_d;
        logic [IW-1:0] held_i;
        got = 0; presented = -1; stall_rem = 5; finished = 1'b0; base = 0;
        held_d = '0; held_i = '0;
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 1;
        check("busy_after_start", busy, 1);
        while (!finished && t < 3000) begin
            if (done) begin
                check("done_timing", t, base + 1);
                check("done_result_count", got, NOUT);
                check("fin_valid_low", out_valid, 0);
                check("fin_busy_low", busy, 0);
                if (start_fin) start = 1'b1;
                finished = 1'b1;
            end else if (out_valid) begin
                if (presented < 0) begin
                    presented = got;
                    check("latency", t, base + CH + 1);
                    check("order_idx", out_idx, got);
                    check("data", out_data, exp_q[got]);
                    held_d = out_data;
                    held_i = out_idx;
                    if (reset_at == got) begin
                        rst_n = 1'b0;
                        #1;
                        check("rst_valid", out_valid, 0);
                        check("rst_busy", busy, 0);
                        check("rst_idx", out_idx, 0);
                        check("rst_data", out_data, 0);
                        @(negedge clk);
                        rst_n = 1'b1;
                        out_ready = 1'b0;
                        return;
                    end
                    if (start_at == got) start = 1'b1;
                end else begin
                    check("hold_idx", out_idx, held_i);
                    check("hold_data", out_data, held_d);
                end
                if (stall_at == got && stall_rem > 0) begin
                    out_ready = 1'b0;
                    stall_rem--;
                end else begin
                    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_ready) begin
                    base = t;
                    got++;
                    presented = -1;
                end
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            t++;
            start = 1'b0;
        end
        if (!finished) check("pass_timeout", 0, 1);
        else begin
            for (int k = 0; k < 6; k++) begin
                check("idle_valid", out_valid, 0);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        fill_const(0, 0);
        repeat (3) @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_idx", out_idx, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_const(1, 0);
        run_pass(-1, -1, 1'b0, -1, 1'b0);

        bias[1] = -30;
        load_and_model();
        run_pass(-1, -1, 1'b0, -1, 1'b0);

        fill_const(1, 0);
        run_pass(10, -1, 1'b0, -1, 1'b0);

        fill_const(-65536, 0);
        run_pass(-1, -1, 1'b0, -1, 1'b0);

        fill_const(1, 0);
        run_pass(-1, 20, 1'b1, -1, 1'b0);

        fill_random();
        run_pass(-1, -1, 1'b0, 50, 1'b0);
        repeat (2) @(negedge clk);
        run_pass(-1, -1, 1'b0, -1, 1'b0);

        for (int p = 0; p < 2; p++) begin
            fill_random();
            run_pass(-1, -1, 1'b0, -1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
